// File: rtl/eth_frame_gen.sv
// Synthetic Ethernet frame source: MAX_PKT frames per start pulse on 64-bit AXI-Stream,
// MAC/EtherType header, 32-bit sequence number, incrementing payload, preamble+IFG idle gap.
module eth_frame_gen #(
  parameter logic [31:0] MAX_PKT   = 32'd10,
  parameter int          FRAME_LEN = 64,
  parameter int          nPreamble = 8,
  parameter int          nIFG      = 12,
  parameter logic [47:0] DST_MAC   = 48'h020000000001,
  parameter logic [47:0] SRC_MAC   = 48'h020000000002,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk156,
  input  logic        cold_reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] pkt_cnt,
  input  logic        m_tready,
  output logic        m_tvalid,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tuser
);
  localparam int          NB        = (FRAME_LEN + 7) / 8;
  localparam int          GAP_CYC   = (nIFG + nPreamble + 7) / 8;
  localparam logic [15:0] LAST_BEAT = 16'(NB - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        tvalid_q, tvalid_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        load_beat;

  // Bytes past FRAME_LEN are driven 0 so the final beat carries no stale data.
  function automatic logic [63:0] beat_data(input logic [15:0] beat, input logic [31:0] seq);
    logic [63:0] data;
    int          idx;
    data = '0;
    for (int k = 0; k < 8; k++) begin
      idx = int'(beat) * 8 + k;
      if (idx >= FRAME_LEN)  data[8*k +: 8] = 8'h00;
      else if (idx < 6)      data[8*k +: 8] = 8'(DST_MAC >> (8 * (5 - idx)));
      else if (idx < 12)     data[8*k +: 8] = 8'(SRC_MAC >> (8 * (11 - idx)));
      else if (idx < 14)     data[8*k +: 8] = 8'(ETHERTYPE >> (8 * (13 - idx)));
      else if (idx < 18)     data[8*k +: 8] = 8'(seq >> (8 * (17 - idx)));
      else                   data[8*k +: 8] = idx[7:0];
    end
    return data;
  endfunction

  function automatic logic [7:0] beat_keep(input logic [15:0] beat);
    logic [7:0] keep;
    keep = '0;
    for (int k = 0; k < 8; k++) keep[k] = (int'(beat) * 8 + k) < FRAME_LEN;
    return keep;
  endfunction

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    pkt_cnt_d = pkt_cnt_q;
    done_d    = done_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    load_beat = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SEND;
          pkt_cnt_d = '0;
          done_d    = 1'b0;
          beat_d    = '0;
          load_beat = 1'b1;
        end
      end
      SEND: begin
        if (tvalid_q && m_tready) begin
          if (beat_q == LAST_BEAT) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            tvalid_d  = 1'b0;
            tdata_d   = '0;
            tkeep_d   = '0;
            tlast_d   = 1'b0;
            gap_d     = GAP_LOAD;
            if (pkt_cnt_d == MAX_PKT) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            beat_d    = beat_q + 16'd1;
            load_beat = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d   = SEND;
          beat_d    = '0;
          load_beat = 1'b1;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // pkt_cnt is stable for the whole frame, so it doubles as the sequence number.
    if (load_beat) begin
      tvalid_d = 1'b1;
      tdata_d  = beat_data(beat_d, pkt_cnt_d);
      tkeep_d  = beat_keep(beat_d);
      tlast_d  = (beat_d == LAST_BEAT);
    end

    busy_d = (state_d == SEND) || (state_d == GAP);
  end

  always_ff @(posedge clk156) begin
    if (!cold_reset_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      gap_q     <= '0;
      pkt_cnt_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      pkt_cnt_q <= pkt_cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;
  assign m_tkeep  = tkeep_q;
  assign m_tlast  = tlast_q;
  assign m_tuser  = 1'b0;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Bench for eth_frame_gen: three instances (64/61/1514-byte frames) checked against a
// byte-queue frame model, with directed runs, random back-pressure and mid-frame reset.
module tb_eth_frame_gen;
  logic clk156       = 1'b0;
  logic cold_reset_n = 1'b0;
  logic m_tready     = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;

  logic        busy0, done0, tvalid0, tlast0, tuser0;
  logic        busy1, done1, tvalid1, tlast1, tuser1;
  logic        busy2, done2, tvalid2, tlast2, tuser2;
  logic [31:0] cnt0, cnt1, cnt2;
  logic [63:0] tdata0, tdata1, tdata2;
  logic [7:0]  tkeep0, tkeep1, tkeep2;

  logic        s_busy, s_done, s_tvalid, s_tlast;
  logic [31:0] s_cnt;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;

  localparam int         FLEN [3]   = '{64, 61, 1514};
  localparam int         MAXP [3]   = '{10, 2, 2};
  localparam int         NBEATS [3] = '{8, 8, 190};
  localparam logic [7:0] LKEEP [3]  = '{8'hFF, 8'h1F, 8'h03};

  int          total = 0;
  int          bad   = 0;
  int          sel   = 0;
  byte unsigned exp_bytes [$];
  logic [63:0] got_beat [3];
  logic [63:0] last_data;
  logic [7:0]  last_keep;

  always #5 clk156 = ~clk156;

  eth_frame_gen u_gen0 (
    .clk156(clk156), .cold_reset_n(cold_reset_n), .start(start0),
    .busy(busy0), .done(done0), .pkt_cnt(cnt0), .m_tready(m_tready),
    .m_tvalid(tvalid0), .m_tdata(tdata0), .m_tkeep(tkeep0), .m_tlast(tlast0), .m_tuser(tuser0)
  );

  eth_frame_gen #(.MAX_PKT(32'd2), .FRAME_LEN(61)) u_gen1 (
    .clk156(clk156), .cold_reset_n(cold_reset_n), .start(start1),
    .busy(busy1), .done(done1), .pkt_cnt(cnt1), .m_tready(m_tready),
    .m_tvalid(tvalid1), .m_tdata(tdata1), .m_tkeep(tkeep1), .m_tlast(tlast1), .m_tuser(tuser1)
  );

  eth_frame_gen #(.MAX_PKT(32'd2), .FRAME_LEN(1514)) u_gen2 (
    .clk156(clk156), .cold_reset_n(cold_reset_n), .start(start2),
    .busy(busy2), .done(done2), .pkt_cnt(cnt2), .m_tready(m_tready),
    .m_tvalid(tvalid2), .m_tdata(tdata2), .m_tkeep(tkeep2), .m_tlast(tlast2), .m_tuser(tuser2)
  );

  always_comb begin
    s_busy = busy0; s_done = done0; s_tvalid = tvalid0; s_tlast = tlast0;
    s_cnt = cnt0; s_tdata = tdata0; s_tkeep = tkeep0;
    if (sel == 1) begin
      s_busy = busy1; s_done = done1; s_tvalid = tvalid1; s_tlast = tlast1;
      s_cnt = cnt1; s_tdata = tdata1; s_tkeep = tkeep1;
    end else if (sel == 2) begin
      s_busy = busy2; s_done = done2; s_tvalid = tvalid2; s_tlast = tlast2;
      s_cnt = cnt2; s_tdata = tdata2; s_tkeep = tkeep2;
    end
  end

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setStart(input int d, input logic v);
    if (d == 0) start0 = v;
    else if (d == 1) start1 = v;
    else start2 = v;
  endtask

  task automatic applyStimulus(input int d);
    setStart(d, 1'b1);
    tick();
    setStart(d, 1'b0);
  endtask

  // Reference frame: header fields concatenated big-endian, then payload byte = index mod 256.
  task automatic modelFrame(input int flen, input logic [31:0] seq);
    logic [143:0] hdr;
    hdr = {48'h020000000001, 48'h020000000002, 16'h88B5, seq};
    exp_bytes.delete();
    for (int i = 0; i < flen; i++) begin
      if (i < 18) exp_bytes.push_back(hdr[143 - 8*i -: 8]);
      else        exp_bytes.push_back(8'(i));
    end
  endtask

  task automatic recvFrame(input int d, input logic [31:0] seq, input bit rnd, input string tag);
    int flen, nb, beats, cyc, byte_err, keep_err, last_err, stall_err, idx;
    bit stalled;
    logic [63:0] pdata;
    logic [7:0]  pkeep;
    logic        plast;
    flen = FLEN[d]; nb = NBEATS[d];
    beats = 0; cyc = 0; byte_err = 0; keep_err = 0; last_err = 0; stall_err = 0;
    stalled = 1'b0; pdata = '0; pkeep = '0; plast = 1'b0;
    modelFrame(flen, seq);
    while (beats < nb && cyc < 5000) begin
      m_tready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (stalled && (!s_tvalid || s_tdata !== pdata || s_tkeep !== pkeep || s_tlast !== plast))
        stall_err++;
      stalled = 1'b0;
      if (s_tvalid) begin
        if (m_tready) begin
          for (int k = 0; k < 8; k++) begin
            idx = beats * 8 + k;
            if (s_tkeep[k] !== (idx < flen)) keep_err++;
            if (idx < flen) begin
              if (s_tdata[8*k +: 8] !== exp_bytes[idx]) byte_err++;
            end else if (s_tdata[8*k +: 8] !== 8'h00) byte_err++;
          end
          if (s_tlast !== (beats == nb - 1)) last_err++;
          if (beats < 3) got_beat[beats] = s_tdata;
          last_data = s_tdata;
          last_keep = s_tkeep;
          beats++;
        end else begin
          stalled = 1'b1;
          pdata = s_tdata; pkeep = s_tkeep; plast = s_tlast;
        end
      end else if (beats > 0) begin
        stall_err++;
      end
      tick();
      cyc++;
    end
    checkOutput({tag, ".beats"}, 64'(beats), 64'(nb));
    checkOutput({tag, ".bytes"}, 64'(byte_err), 64'd0);
    checkOutput({tag, ".keep"}, 64'(keep_err), 64'd0);
    checkOutput({tag, ".last"}, 64'(last_err), 64'd0);
    checkOutput({tag, ".stall"}, 64'(stall_err), 64'd0);
  endtask

  task automatic waitValid(input int d, input bit pulse, output int idle);
    idle = 0;
    while (!s_tvalid && idle < 100) begin
      if (pulse && idle == 0) setStart(d, 1'b1);
      tick();
      setStart(d, 1'b0);
      idle++;
    end
  endtask

  task automatic runFrames(input int d, input bit rnd, input int pulse_at, input string tag);
    int idle;
    sel = d;
    #0;
    applyStimulus(d);
    checkOutput({tag, ".lat_valid"}, 64'(s_tvalid), 64'd1);
    checkOutput({tag, ".start_busy"}, 64'(s_busy), 64'd1);
    checkOutput({tag, ".start_done"}, 64'(s_done), 64'd0);
    checkOutput({tag, ".start_cnt"}, 64'(s_cnt), 64'd0);
    for (int f = 0; f < MAXP[d]; f++) begin
      recvFrame(d, 32'(f), rnd, $sformatf("%s.f%0d", tag, f));
      checkOutput($sformatf("%s.f%0d.cnt", tag, f), 64'(s_cnt), 64'(f + 1));
      checkOutput($sformatf("%s.f%0d.lkeep", tag, f), 64'(last_keep), 64'(LKEEP[d]));
      if (d == 1) checkOutput($sformatf("%s.f%0d.lhigh", tag, f), 64'(last_data[63:40]), 64'd0);
      if (d == 0 && f == 0) begin
        checkOutput({tag, ".hdr_b0"}, got_beat[0], 64'h0002_0100_0000_0002);
        checkOutput({tag, ".hdr_b1"}, got_beat[1], 64'h0000_B588_0200_0000);
        checkOutput({tag, ".hdr_b2"}, got_beat[2], 64'h1716_1514_1312_0000);
      end
      if (d == 0 && f == 3) checkOutput({tag, ".f3_b2"}, got_beat[2], 64'h1716_1514_1312_0300);
      if (f < MAXP[d] - 1) begin
        checkOutput($sformatf("%s.f%0d.gap_busy", tag, f), 64'(s_busy), 64'd1);
        waitValid(d, f == pulse_at, idle);
        checkOutput($sformatf("%s.f%0d.gap", tag, f), 64'(idle), 64'd3);
      end else begin
        checkOutput({tag, ".end_done"}, 64'(s_done), 64'd1);
        checkOutput({tag, ".end_busy"}, 64'(s_busy), 64'd0);
      end
    end
  endtask

  initial begin
    int idle;
    $display("[TB] reset");
    cold_reset_n = 1'b0;
    tick();
    tick();
    checkOutput("rst.tvalid", 64'(tvalid0), 64'd0);
    checkOutput("rst.tdata", tdata0, 64'd0);
    checkOutput("rst.tkeep", 64'(tkeep0), 64'd0);
    checkOutput("rst.tlast", 64'(tlast0), 64'd0);
    checkOutput("rst.busy", 64'(busy0), 64'd0);
    checkOutput("rst.done", 64'(done0), 64'd0);
    checkOutput("rst.cnt", 64'(cnt0), 64'd0);
    checkOutput("rst.tuser", {61'd0, tuser0, tuser1, tuser2}, 64'd0);
    cold_reset_n = 1'b1;
    tick();

    $display("[TB] full-rate run with start pulsed during a gap");
    runFrames(0, 1'b0, 4, "run0");

    $display("[TB] restart after done with random ready");
    runFrames(0, 1'b1, -1, "rnd");

    $display("[TB] reset during frame 2 beat 4");
    sel = 0;
    applyStimulus(0);
    recvFrame(0, 32'd0, 1'b0, "rr.f0");
    waitValid(0, 1'b0, idle);
    recvFrame(0, 32'd1, 1'b0, "rr.f1");
    waitValid(0, 1'b0, idle);
    checkOutput("rr.f2_valid", 64'(s_tvalid), 64'd1);
    for (int b = 0; b < 4; b++) tick();
    checkOutput("rr.f2_b4", s_tdata, 64'h2726_2524_2322_2120);
    cold_reset_n = 1'b0;
    tick();
    cold_reset_n = 1'b1;
    checkOutput("rr.tvalid", 64'(s_tvalid), 64'd0);
    checkOutput("rr.cnt", 64'(s_cnt), 64'd0);
    checkOutput("rr.busy", 64'(s_busy), 64'd0);
    checkOutput("rr.tlast", 64'(s_tlast), 64'd0);
    applyStimulus(0);
    recvFrame(0, 32'd0, 1'b0, "rr.new");
    checkOutput("rr.new.cnt", 64'(s_cnt), 64'd1);

    $display("[TB] 61-byte frames");
    runFrames(1, 1'b0, -1, "len61");

    $display("[TB] 1514-byte frames");
    runFrames(2, 1'b0, -1, "len1514");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
